// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin sharing of one 32-bit comparator between NREQ
// requesters. Each grant drives the comparator combinationally and the
// result is captured in that requester's response slot. The slot holds
// the result until the requester takes it.

module cmp_arbiter_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        grant_i,
  input  logic        ready_i,
  input  logic [31:0] d_i,
  output logic        valid_o,
  output logic [31:0] result_o
);
  logic        valid_q;
  logic [31:0] result_q;

  // Capture on grant and clear on handshake. A grant only happens while
  // the slot is empty, so the two branches never compete.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (grant_i) begin
      valid_q  <= 1'b1;
      result_q <= d_i;
    end else if (valid_q && ready_i) begin
      valid_q  <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
endmodule

module cmp_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_x,
  input  logic [32*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [32*NREQ-1:0]   rsp_result,
  output logic [3:0]           cmp_operation,
  output logic [31:0]          cmp_x,
  output logic [31:0]          cmp_y,
  input  logic [31:0]          cmp_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] gidx;
  logic          gnt_any;

  // Rotating priority starting at last+1. Eligibility uses the registered
  // slot state only, so rsp_ready never reaches req_ready.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_any   = 1'b0;
    gidx      = '0;
    req_ready = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!gnt_any && req_valid[idx] && !rsp_valid[idx]) begin
        gnt_any = 1'b1;
        gidx    = IW'(idx);
      end
    end
    if (gnt_any) req_ready[gidx] = 1'b1;
    last_d = gnt_any ? gidx : last_q;
  end

  // Comparator inputs come from the granted requester, or are zero when idle.
  always_comb begin
    cmp_operation = '0;
    cmp_x         = '0;
    cmp_y         = '0;
    if (gnt_any) begin
      cmp_operation = req_op[4*int'(gidx) +: 4];
      cmp_x         = req_x[32*int'(gidx) +: 32];
      cmp_y         = req_y[32*int'(gidx) +: 32];
    end
  end

  // Most recently granted index. Resetting it to NREQ-1 gives requester 0
  // top priority.
  always_ff @(posedge clk) begin
    if (reset) last_q <= IW'(NREQ - 1);
    else       last_q <= last_d;
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    cmp_arbiter_slot u_slot (
      .clk      (clk),
      .reset    (reset),
      .grant_i  (req_ready[i]),
      .ready_i  (rsp_ready[i]),
      .d_i      (cmp_o),
      .valid_o  (rsp_valid[i]),
      .result_o (rsp_result[32*i +: 32])
    );
  end
endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shares a single 32-bit Comparator instance between `NREQ` requesters, such as the branch unit and the SLT/SLTU path. Uses round-robin arbitration with valid/ready handshakes on both sides. The block drives the comparator's `operation`/`X`/`Y` inputs from the granted requester, registers the comparator output into a per-requester response slot, and holds each result until that requester accepts it. It sits between the decode/execute stages and the comparator datapath.

## Interface
- `NREQ`, default 2: number of requesters. Legal range is 2..8.
- `clk`  in  1  clock. Everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_ready`  out  NREQ  request accepted this cycle (grant).
- `req_op`  in  4*NREQ  comparator operation for requester i, at bits [4i+3:4i]. Encoding is funct3: 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU.
- `req_x`  in  32*NREQ  operand X for requester i, at bits [32i+31:32i].
- `req_y`  in  32*NREQ  operand Y for requester i, same packing as `req_x`.
- `rsp_valid`  out  NREQ  response slot i holds a result.
- `rsp_ready`  in  NREQ  requester i consumes its result.
- `rsp_result`  out  32*NREQ  result for requester i. Only bit 0 can be nonzero when the comparator behaves correctly.
- `cmp_operation`  out  4  to comparator `operation`.
- `cmp_x`  out  32  to comparator `X`.
- `cmp_y`  out  32  to comparator `Y`.
- `cmp_o`  in  32  from comparator `O` (combinational, same cycle).

## Operation
**Eligibility**
- Requester i is eligible when `req_valid[i]` is 1 and `rsp_valid[i]` is 0 (its slot is empty).
- A slot being drained in the same cycle does not count as empty. This deliberately keeps `rsp_ready` out of the `req_ready` path.

**Arbitration**
- Round-robin over eligible requesters. Priority starts at `last+1` (mod NREQ) and wraps.
- `last` is a register holding the most recently granted index. It resets to NREQ-1, so requester 0 has top priority after reset.
- At most one `req_ready` bit is high per cycle. It is combinational from `req_valid`, `rsp_valid` and `last`.
- If nothing is eligible, `req_ready` is all 0 and `last` holds.

**Granted cycle (requester g)**
- `cmp_operation`/`cmp_x`/`cmp_y` carry g's fields.
- At the clock edge: `rsp_result[g] <= cmp_o`, `rsp_valid[g] <= 1`, `last <= g`.

**Idle cycle**
- `cmp_*` outputs are driven to 0, which is operation EQ on 0/0. The result is not captured.

**Response slots**
- Slot i clears at the edge where `rsp_valid[i]` and `rsp_ready[i]` are both 1.
- `rsp_result[i]` is stable while `rsp_valid[i]` is 1.
- `rsp_ready[i]` is ignored while `rsp_valid[i]` is 0.

**Operand and result handling**
- Op codes are passed through unmodified. Undefined codes (2, 3, 8..15) yield result 0, the comparator's default, and still complete normally with `rsp_valid` asserted.
- Results are not altered. The full 32 bits of `cmp_o` are stored.

**Requester obligations**
- `req_*` fields must remain stable while `req_valid` is 1 and `req_ready` is 0.
- A requester may drop `req_valid` before it is granted.

## Timing
**Reset**
- Values after reset: `rsp_valid` = 0, `rsp_result` = 0, `last` = NREQ-1.
- Combinational outputs settle from those values: `req_ready` = 0 unless requests are present, and `cmp_*` = 0.
- Reset asserted mid-operation discards all pending results. Any grant in the reset cycle is void and captures nothing.

**Latency and throughput**
- Latency is 1 cycle: a grant in cycle n gives `rsp_valid` high in cycle n+1.
- Aggregate throughput is 1 compare per cycle.
- Per-requester throughput is at most 1 per 2 cycles: grant, then drain, then eligible again.
- With `rsp_ready` held low, slot i holds indefinitely and requester i is never granted. Other requesters are unaffected.

**Simultaneous events**
- All eligible requesters asserting together are served in rotating order with no starvation.
- The worst-case wait is NREQ-1 grants after becoming eligible.

## Test plan
1. **Single request.** NREQ=2. Requester 0: op=4, X=0xFFFFFFFF, Y=1, valid for one cycle. Expect `req_ready[0]`=1 in that cycle. Next cycle expect `rsp_valid[0]`=1, `rsp_result[0]`=1. With op=6 and the same operands, expect result 0.
2. **Round robin.** Both requesters hold valid continuously with `rsp_ready` tied 1. After reset the grant order is 0,1,0,1,… Each response carries its own requester's compare result: requester 0 op=0 with X=Y=5 gives 1; requester 1 op=1 with X=Y=5 gives 0.
3. **Backpressure.** `rsp_ready[1]`=0 for 5 cycles after requester 1's result arrives. Result stays 1 and stable. Requester 1 gets no grant while requester 0 continues to be granted. Releasing ready clears the slot, and requester 1 is granted on the following cycle.
4. **Undefined op.** op=2, X=3, Y=3. Expect `rsp_valid` to assert with result 0.
5. **Reset mid-flight.** Assert `reset` in the cycle after a grant, while `rsp_valid[0]`=1. Next cycle `rsp_valid` is all 0. The first grant after reset goes to requester 0 when both are requesting.
6. **NREQ=4, all valid, ready=1.** Expect grant sequence 0,1,2,3,0. Drop requester 2's valid and expect the sequence to continue 1,3,0,1.
